// File: rtl/conv_pingpong_ram.sv
// Double-buffered feature-map RAM: producer fills one bank while the consumer drains the other,
// with bank ownership handed over through done/ready handshakes and a fixed-latency read pipeline.
module conv_pingpong_ram #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  output logic                  wr_bank,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic                  rd_ready,
  output logic                  rd_bank,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            level
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];
  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic                  wptr;
  logic                  rptr;
  logic                  wr_acc;
  logic                  wr_commit;
  logic                  rd_acc;
  logic                  rd_rel;
  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

  // Status outputs are pure decodes of the bank flags and pointers.
  assign wr_ready  = ~full[wptr];
  assign rd_ready  = full[rptr];
  assign wr_bank   = wptr;
  assign rd_bank   = rptr;
  assign level     = 2'(full[0]) + 2'(full[1]);
  assign rd_valid  = vld[RD_LATENCY-1];
  assign rd_data   = dat[RD_LATENCY-1];

  assign wr_acc    = wr_en & wr_ready;
  assign wr_commit = wr_done & wr_ready;
  assign rd_acc    = rd_en & rd_ready;
  assign rd_rel    = rd_done & rd_ready;

  // Commit and release never target the same bank, so both may apply together.
  always_comb begin
    full_nxt = full;
    if (wr_commit) full_nxt[wptr] = 1'b1;
    if (rd_rel)    full_nxt[rptr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_commit) wptr <= ~wptr;
      if (rd_rel)    rptr <= ~rptr;
    end
  end

  // Bank storage is left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wptr, wr_addr}] <= wr_data;
  end

  // Bank index is sampled at issue; each data stage only advances on a valid so the output holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= rd_acc;
      if (rd_acc) dat[0] <= mem[{rptr, rd_addr}];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

endmodule

// File: tb/tb_conv_pingpong_ram.sv
// Scoreboard bench for conv_pingpong_ram: a full-size instance plus two small instances
// with read latencies 1 and 4 driven by shared stimulus.
module tb_conv_pingpong_ram;

  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 10;
  localparam int unsigned L   = 2;
  localparam int unsigned SDW = 64;
  localparam int unsigned SAW = 4;

  typedef struct {
    logic [127:0] data;
    int unsigned  due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q_m[$];
  exp_t q_1[$];
  exp_t q_4[$];

  // main instance signals
  logic          m_wr_en = 0, m_wr_done = 0, m_rd_en = 0, m_rd_done = 0;
  logic [AW-1:0] m_wr_addr = '0, m_rd_addr = '0;
  logic [DW-1:0] m_wr_data = '0;
  logic          m_wr_ready, m_wr_bank, m_rd_ready, m_rd_bank, m_rd_valid;
  logic [DW-1:0] m_rd_data;
  logic [1:0]    m_level;

  // shared small-instance inputs
  logic           s_wr_en = 0, s_wr_done = 0, s_rd_en = 0, s_rd_done = 0;
  logic [SAW-1:0] s_wr_addr = '0, s_rd_addr = '0;
  logic [SDW-1:0] s_wr_data = '0;
  logic           s1_wr_ready, s1_wr_bank, s1_rd_ready, s1_rd_bank, s1_rd_valid;
  logic [SDW-1:0] s1_rd_data;
  logic [1:0]     s1_level;
  logic           s4_wr_ready, s4_wr_bank, s4_rd_ready, s4_rd_bank, s4_rd_valid;
  logic [SDW-1:0] s4_rd_data;
  logic [1:0]     s4_level;

  conv_pingpong_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L)) u_dut (
    .clk(clk), .rst(rst),
    .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_data(m_wr_data), .wr_done(m_wr_done),
    .wr_ready(m_wr_ready), .wr_bank(m_wr_bank),
    .rd_en(m_rd_en), .rd_addr(m_rd_addr), .rd_done(m_rd_done),
    .rd_ready(m_rd_ready), .rd_bank(m_rd_bank), .rd_valid(m_rd_valid), .rd_data(m_rd_data),
    .level(m_level));

  conv_pingpong_ram #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW), .RD_LATENCY(1)) u_s1 (
    .clk(clk), .rst(rst),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_done(s_wr_done),
    .wr_ready(s1_wr_ready), .wr_bank(s1_wr_bank),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_done(s_rd_done),
    .rd_ready(s1_rd_ready), .rd_bank(s1_rd_bank), .rd_valid(s1_rd_valid), .rd_data(s1_rd_data),
    .level(s1_level));

  conv_pingpong_ram #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW), .RD_LATENCY(4)) u_s4 (
    .clk(clk), .rst(rst),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_done(s_wr_done),
    .wr_ready(s4_wr_ready), .wr_bank(s4_wr_bank),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_done(s_rd_done),
    .rd_ready(s4_rd_ready), .rd_bank(s4_rd_bank), .rd_valid(s4_rd_valid), .rd_data(s4_rd_data),
    .level(s4_level));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic m_idle();
    m_wr_en = 0; m_wr_done = 0; m_rd_en = 0; m_rd_done = 0;
  endtask

  task automatic m_status(input string tag, input logic wrr, input logic wb, input logic rdr,
                          input logic rb, input logic [1:0] lv);
    check({tag, " wr_ready"}, 128'(m_wr_ready), 128'(wrr));
    check({tag, " wr_bank"},  128'(m_wr_bank),  128'(wb));
    check({tag, " rd_ready"}, 128'(m_rd_ready), 128'(rdr));
    check({tag, " rd_bank"},  128'(m_rd_bank),  128'(rb));
    check({tag, " level"},    128'(m_level),    128'(lv));
  endtask

  task automatic m_read(input int unsigned a, input logic [127:0] d);
    m_rd_en = 1; m_rd_addr = AW'(a);
    q_m.push_back('{d, cyc + L});
  endtask

  // monitors: pop one expectation per presented word, checking data and arrival cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_rd_valid) begin
      if (q_m.size() == 0) check("main unexpected rd_valid", 128'(m_rd_valid), 128'(0));
      else begin
        e = q_m.pop_front();
        check("main rd_data", m_rd_data, e.data);
        check("main rd latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && s1_rd_valid) begin
      if (q_1.size() == 0) check("lat1 unexpected rd_valid", 128'(s1_rd_valid), 128'(0));
      else begin
        e = q_1.pop_front();
        check("lat1 rd_data", 128'(s1_rd_data), e.data);
        check("lat1 rd latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && s4_rd_valid) begin
      if (q_4.size() == 0) check("lat4 unexpected rd_valid", 128'(s4_rd_valid), 128'(0));
      else begin
        e = q_4.pop_front();
        check("lat4 rd_data", 128'(s4_rd_data), e.data);
        check("lat4 rd latency", 128'(cyc), 128'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    rst = 0;
    step();
    m_status("reset", 1, 0, 0, 0, 0);
    check("reset rd_valid", 128'(m_rd_valid), 128'(0));
    check("reset rd_data", m_rd_data, 128'(0));

    // fill bank 0 with addr i -> data i, commit with the last write
    for (int i = 0; i < 1024; i++) begin
      m_wr_en = 1; m_wr_addr = AW'(i); m_wr_data = 128'(i); m_wr_done = (i == 1023);
      if (i == 1023) check("pre-commit rd_ready", 128'(m_rd_ready), 128'(0));
      step();
    end
    m_idle();
    m_status("after commit0", 1, 1, 1, 0, 1);

    for (int i = 0; i < 1024; i++) begin
      m_read(i, 128'(i));
      step();
    end
    m_idle();

    // write part of bank 1, then commit it while releasing bank 0 with a final read of word 7
    for (int j = 0; j < 16; j++) begin
      m_wr_en = 1; m_wr_addr = AW'(j); m_wr_data = 128'h0000_B000 + 128'(j);
      step();
    end
    m_idle();
    m_wr_done = 1; m_rd_done = 1;
    m_read(7, 128'(7));
    step();
    m_idle();
    m_status("swap", 1, 0, 1, 1, 1);

    m_read(5, 128'h0000_B005);
    step();
    m_idle();

    // fill bank 0 again so both banks are full
    m_wr_en = 1; m_wr_addr = AW'(3); m_wr_data = 128'h0000_AAAA; m_wr_done = 1;
    step();
    m_idle();
    m_status("both full", 0, 1, 1, 1, 2);

    m_wr_en = 1; m_wr_addr = AW'(5); m_wr_data = 128'h0000_DEAD; m_wr_done = 1;
    step();
    m_idle();
    m_status("ignored write", 0, 1, 1, 1, 2);
    m_read(5, 128'h0000_B005);
    step();
    m_idle();

    // release bank 1: write side may reuse it at once
    m_rd_done = 1;
    step();
    m_idle();
    m_status("release1", 1, 1, 1, 0, 1);

    m_read(3, 128'h0000_AAAA); step();
    m_read(7, 128'(7));        step();
    m_read(5, 128'(5)); m_rd_done = 1; step();
    m_idle();
    m_status("all empty", 1, 1, 0, 1, 0);

    // reads and releases with nothing full are ignored
    m_rd_en = 1; m_rd_addr = AW'(0); m_rd_done = 1;
    step();
    m_idle();
    m_status("ignored read", 1, 1, 0, 1, 0);
    repeat (L + 3) step();
    check("main queue drained", 128'(q_m.size()), 128'(0));

    // reset with two reads in flight: nothing may emerge
    m_wr_done = 1;
    step();
    m_idle();
    check("burst rd_ready", 128'(m_rd_ready), 128'(1));
    m_rd_en = 1; m_rd_addr = AW'(0);
    step();
    m_rd_addr = AW'(1); rst = 1;
    step();
    m_idle();
    m_status("mid-burst reset", 1, 0, 0, 0, 0);
    check("mid-burst rd_valid", 128'(m_rd_valid), 128'(0));
    check("mid-burst rd_data", m_rd_data, 128'(0));
    rst = 0;
    repeat (L + 3) step();
    check("post-reset rd_data", m_rd_data, 128'(0));
    check("post-reset queue", 128'(q_m.size()), 128'(0));

    // small instances: latency 1 and 4 on the same fill/read-back pattern
    for (int i = 0; i < 16; i++) begin
      s_wr_en = 1; s_wr_addr = SAW'(i); s_wr_data = 64'hA5A5_0000_0000_0000 | 64'(i);
      s_wr_done = (i == 15);
      step();
    end
    s_wr_en = 0; s_wr_done = 0;
    check("lat1 wr_bank", 128'(s1_wr_bank), 128'(1));
    check("lat1 rd_ready", 128'(s1_rd_ready), 128'(1));
    check("lat1 level", 128'(s1_level), 128'(1));
    check("lat4 wr_bank", 128'(s4_wr_bank), 128'(1));
    check("lat4 rd_ready", 128'(s4_rd_ready), 128'(1));
    check("lat4 level", 128'(s4_level), 128'(1));
    for (int i = 0; i < 16; i++) begin
      s_rd_en = 1; s_rd_addr = SAW'(i);
      q_1.push_back('{128'(64'hA5A5_0000_0000_0000 | 64'(i)), cyc + 1});
      q_4.push_back('{128'(64'hA5A5_0000_0000_0000 | 64'(i)), cyc + 4});
      step();
    end
    s_rd_en = 0;
    repeat (8) step();
    check("lat1 queue drained", 128'(q_1.size()), 128'(0));
    check("lat4 queue drained", 128'(q_4.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_pingpong_ram.md
# conv_pingpong_ram

Parametrised double-buffered (ping-pong) feature-map RAM sitting between a convolution layer's output writer and the next layer's reader. Two banks of 2^ADDR_WIDTH words × DATA_WIDTH bits. The producer fills one bank while the consumer drains the other. Bank ownership passes through explicit done/ready handshakes. Read latency is configurable and tracked by a valid pipeline.

## Interface
- DATA_WIDTH, 128, word width in bits
- ADDR_WIDTH, 10, per-bank address width; bank depth = 2^ADDR_WIDTH
- RD_LATENCY, 2, read latency in cycles, legal range 1..4
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe; honoured only while wr_ready=1
- wr_addr  in  ADDR_WIDTH  write address within the current write bank
- wr_data  in  DATA_WIDTH  write data
- wr_done  in  1  producer commits the current write bank; honoured only while wr_ready=1
- wr_ready  out  1  current write bank is empty and writable
- wr_bank  out  1  index of the current write bank
- rd_en  in  1  read strobe; honoured only while rd_ready=1
- rd_addr  in  ADDR_WIDTH  read address within the current read bank
- rd_done  in  1  consumer releases the current read bank; honoured only while rd_ready=1
- rd_ready  out  1  current read bank is full and readable
- rd_bank  out  1  index of the current read bank
- rd_valid  out  1  rd_data carries the result of an accepted read
- rd_data  out  DATA_WIDTH  read data
- level  out  2  number of full banks (0..2)

## Operation
- State: full[1:0] flags, wptr and rptr (1 bit each), valid shift register of depth RD_LATENCY, and a data pipeline of depth RD_LATENCY.
- wr_ready = !full[wptr]; rd_ready = full[rptr]; wr_bank = wptr; rd_bank = rptr; level = full[0]+full[1].
- Accepted write (wr_en & wr_ready): mem[wptr][wr_addr] <= wr_data.
- Accepted commit (wr_done & wr_ready): full[wptr] <= 1 and wptr toggles. A write in the same cycle lands in the bank being committed.
- Accepted read (rd_en & rd_ready): reads mem[rptr][rd_addr]. The bank index is captured at issue, so in-flight reads are unaffected by later pointer moves.
- Accepted release (rd_done & rd_ready): full[rptr] <= 0 and rptr toggles. A read in the same cycle is still issued and returns normally. Bank contents are not cleared.
- wr_done and rd_done in the same cycle both take effect. They always address different banks or are mutually exclusive by the ready terms.
- Ignored inputs: wr_en or wr_done with wr_ready=0; rd_en or rd_done with rd_ready=0. These produce no state change, no write, and no rd_valid.
- Per-bank lifecycle: EMPTY → (writes) → commit → FULL → (reads) → release → EMPTY. Pointers alternate 0,1,0,1…
- rst: full=00, wptr=0, rptr=0, valid pipeline cleared, rd_valid=0, rd_data=0, level=0, wr_ready=1, rd_ready=0. Memory contents are not reset. Reads in flight at rst are discarded.

## Timing
- Writes take effect at the clock edge where they are accepted.
- After a commit at edge N, rd_ready and level reflect it from cycle N+1. A read at N+1 returns the data of every write accepted up to and including edge N.
- rd_valid and rd_data appear exactly RD_LATENCY cycles after the accepted rd_en edge. Back-to-back reads give back-to-back valid data, with throughput of 1 word per cycle.
- rd_data holds its last valid value while rd_valid=0 (0 after reset).
- A release at edge N frees the bank: wr_ready rises at N+1 if wptr points to it.
- With both banks full: wr_ready=0 and level=2. With both empty: rd_ready=0 and level=0.

## Test plan
- Reset, then fill bank 0 with addr i → data i, i=0..1023. Assert wr_done at the last write. Expect wr_bank=1, rd_ready=1 and level=1 the next cycle. Read 0..1023 back-to-back: rd_valid high for 1024 cycles starting RD_LATENCY cycles after the first rd_en, with rd_data=i in order.
- Commit both banks without releasing. Expect wr_ready=0 and level=2. Then issue wr_en addr 5 data 0xDEAD: the write is ignored and a later read of addr 5 returns the original data.
- Same-cycle wr_done on bank 1 and rd_done on bank 0 while level=1. Expect level to stay 1, wptr=0, rptr=1, wr_ready=1 and rd_ready=1.
- rd_en addr 7 together with rd_done. Expect rd_valid with bank-0 word 7 after RD_LATENCY cycles, even though rd_bank is already 1.
- Assert rst mid-read-burst with 2 reads in flight. Expect no rd_valid afterwards, rd_data=0 and level=0. Outputs match the reset state.
- Rerun the first scenario with RD_LATENCY=1 and RD_LATENCY=4, DATA_WIDTH=64 and ADDR_WIDTH=4. Expect latency to match exactly and data to be correct.
